golden_nonce_collector: RTL and testbench
=========================================

GOLDEN_NONCE_COLLECTOR -- requirements
Module: golden_nonce_collector

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from nonce_valid_i sampling to the matching success_i (range 1..255).
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse that begins a new job.
REQ-006 SHALL have port nonce_i  input  32  nonce issued to the hash pipeline this cycle.
REQ-007 SHALL have port nonce_valid_i  input  1  nonce_i is valid this cycle.
REQ-008 SHALL have port nonce_last_i  input  1  qualifies the final nonce of the job; meaningful only with nonce_valid_i.
REQ-009 SHALL have port success_i  input  1  registered validator verdict, LATENCY cycles after its nonce.
REQ-010 SHALL have port result_nonce_o  output  32  winning nonce at the FIFO head.
REQ-011 SHALL have port result_valid_o  output  1  FIFO non-empty.
REQ-012 SHALL have port result_ready_i  input  1  consumer accepts the head entry.
REQ-013 SHALL have port busy_o  output  1  state is RUN.
REQ-014 SHALL have port done_o  output  1  state is DONE.
REQ-015 SHALL have port overflow_o  output  1  sticky: a winner was dropped.
REQ-016 SHALL have port win_count_o  output  8  saturating count of winners detected in the current job.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 SHALL transition from any state to RUN on start_i.
REQ-019 SHALL transition RUN->DONE when the delayed entry carrying last retires.
REQ-020 SHALL hold DONE until start_i; IDLE is entered only by reset.
REQ-021 SHALL, on start_i, clear the delay line, FIFO, overflow_o and win_count_o in the same edge; a nonce_valid_i coincident with start_i is ignored.
REQ-022 SHALL capture {nonce_i, nonce_last_i} into a LATENCY-stage delay line only when state is RUN and nonce_valid_i=1; otherwise insert a bubble (valid=0).
REQ-023 SHALL define winner = delay-line output valid AND success_i; success_i with an invalid delayed slot is ignored.
REQ-024 SHALL push the delayed nonce into the FIFO on winner when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-025 SHALL, on winner with the FIFO full and no same-cycle pop, drop the nonce and set overflow_o (sticky until start_i or reset).
REQ-026 SHALL increment win_count_o on every winner (dropped or not), saturating at 255.
REQ-027 SHALL pop when result_valid_o AND result_ready_i; result_nonce_o SHALL be stable while result_valid_o=1 and not popped.
REQ-028 SHALL accept a simultaneous push and pop on a non-empty FIFO with occupancy unchanged.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-030 SHALL still evaluate winner and push for the last entry on the same edge as the RUN->DONE transition.
REQ-031 SHALL let the FIFO continue draining in DONE.
REQ-032 SHALL ignore nonce_valid_i in DONE.
REQ-033 SHALL give a latency of 1 cycle from a winner edge to result_valid_o when the FIFO was empty (no fall-through).

Reset
REQ-034 SHALL, on rst_n low, asynchronously enter IDLE and clear the delay line and FIFO pointers.
REQ-035 SHALL drive all outputs to 0 during reset: result_valid_o, busy_o, done_o, overflow_o, win_count_o, result_nonce_o.
REQ-036 SHALL, on reset asserted mid-job, discard all in-flight and buffered nonces.
REQ-037 SHALL permit deassertion at any time; the first start_i after deassertion is honoured.

Verification (LATENCY=4, DEPTH=4)
REQ-038 SHALL cover the single-winner scenario: start; nonces 0x10..0x17 on consecutive cycles, last on 0x17; success_i high only 4 cycles after 0x13 -> result_nonce_o=0x13, win_count_o=1, done_o 4 cycles after 0x17.
REQ-039 SHALL cover the overflow scenario: 6 consecutive winners 0xA0..0xA5 with result_ready_i=0 -> FIFO holds 0xA0..0xA3, overflow_o=1, win_count_o=6; draining yields those 4 in order.
REQ-040 SHALL cover full FIFO with simultaneous pop and winner 0xB4 -> 0xB4 accepted, overflow_o stays 0.
REQ-041 SHALL cover the bubble scenario: success_i pulsed in slots with no valid nonce -> no push, win_count_o=0.
REQ-042 SHALL cover the restart scenario: start_i mid-job with 2 entries in flight and 1 in the FIFO -> FIFO empty, counters 0, in-flight successes ignored next cycle.
REQ-043 SHALL cover the async-reset scenario: rst_n pulsed low between clock edges mid-job -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/golden_nonce_collector.sv
// Collects winning nonces: delays each issued nonce by the validator latency,
// pairs it with success_i, and buffers winners in a small result FIFO.
//
// state | meaning
// IDLE  | after reset, waiting for the first start_i
// RUN   | accepting nonces, job in progress
// DONE  | last nonce has retired; FIFO may still drain
module golden_nonce_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] nonce_i,
  input  logic        nonce_valid_i,
  input  logic        nonce_last_i,
  input  logic        success_i,
  output logic [31:0] result_nonce_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [7:0]  win_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [LATENCY-1:0] dl_valid;
  logic [LATENCY-1:0] dl_last;
  logic [31:0]        dl_nonce [LATENCY];

  logic [31:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  logic capture, winner, retire;
  logic empty, full, push, pop, drop;

  assign capture = (state_q == RUN) && nonce_valid_i && !start_i;
  assign winner  = dl_valid[LATENCY-1] && success_i;
  assign retire  = dl_valid[LATENCY-1] && dl_last[LATENCY-1];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && result_ready_i;
  // A full FIFO still takes a winner if the head leaves on the same edge.
  assign push  = winner && (!full || pop);
  assign drop  = winner && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i)                       state_d = RUN;
    else if (state_q == RUN && retire) state_d = DONE;
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      dl_last  <= '0;
      for (int i = 0; i < LATENCY; i++) dl_nonce[i] <= '0;
    end else if (start_i) begin
      dl_valid <= '0;
      dl_last  <= '0;
      for (int i = 0; i < LATENCY; i++) dl_nonce[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_last[i]  <= dl_last[i-1];
        dl_nonce[i] <= dl_nonce[i-1];
      end
      dl_valid[0] <= capture;
      dl_last[0]  <= capture && nonce_last_i;
      dl_nonce[0] <= nonce_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !start_i) fifo_mem[wr_ptr[AW-1:0]] <= dl_nonce[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      win_count_o <= '0;
    end else if (start_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      win_count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow_o <= 1'b1;
      if (winner && win_count_o != 8'hFF) win_count_o <= win_count_o + 8'd1;
    end
  end

  assign result_valid_o = !empty;
  // Gate the head so the output reads zero whenever the FIFO is empty or in reset.
  assign result_nonce_o = empty ? 32'h0 : fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Scoreboard bench for golden_nonce_collector (LATENCY=4, DEPTH=4): expected
// winners are queued at stimulus time and checked as the consumer pops them.
module tb_golden_nonce_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] nonce_i = '0;
  logic        nonce_valid_i = 1'b0;
  logic        nonce_last_i = 1'b0;
  logic        success_i = 1'b0;
  logic [31:0] result_nonce_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        busy_o, done_o, overflow_o;
  logic [7:0]  win_count_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  golden_nonce_collector #(.LATENCY(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .nonce_i(nonce_i),
    .nonce_valid_i(nonce_valid_i), .nonce_last_i(nonce_last_i),
    .success_i(success_i), .result_nonce_o(result_nonce_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
    .win_count_o(win_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (rst_n && !start_i && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected none", result_nonce_o);
      end else begin
        check("sb_nonce", result_nonce_o, exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] n, input bit l, input bit s, input bit st);
    nonce_valid_i = v;
    nonce_i       = n;
    nonce_last_i  = l;
    success_i     = s;
    start_i       = st;
    if (st) exp_q.delete();
    @(posedge clk);
    #1;
    nonce_valid_i = 1'b0;
    success_i     = 1'b0;
    start_i       = 1'b0;
    nonce_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    #2;
    check("rst_valid", {31'b0, result_valid_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_wins", {24'b0, win_count_o}, 0);
    check("rst_nonce", result_nonce_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single winner: only 0x13 succeeds, done four edges after 0x17.
    result_ready_i = 1'b1;
    step(0, 0, 0, 0, 1);
    check("s1_busy", {31'b0, busy_o}, 1);
    exp_q.push_back(32'h13);
    for (int i = 0; i < 17; i++) begin
      step(i < 8 || i == 12, (i == 12) ? 32'h99 : 32'h10 + i, i == 7, i == 7 || i == 16, 0);
      if (i == 10) check("s1_not_done", {31'b0, done_o}, 0);
      if (i == 11) check("s1_done", {31'b0, done_o}, 1);
    end
    check("s1_wins", {24'b0, win_count_o}, 1);
    check("s1_sb_empty", exp_q.size(), 0);

    // Overflow: six winners into a four-deep FIFO with no consumer.
    result_ready_i = 1'b0;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    for (int i = 0; i < 10; i++)
      step(i < 6, 32'hA0 + i, i == 5, i >= 4, 0);
    check("s2_overflow", {31'b0, overflow_o}, 1);
    check("s2_wins", {24'b0, win_count_o}, 6);
    check("s2_done", {31'b0, done_o}, 1);
    check("s2_head", result_nonce_o, 32'hA0);
    result_ready_i = 1'b1;
    idle(6);
    check("s2_sb_empty", exp_q.size(), 0);
    check("s2_drained", {31'b0, result_valid_o}, 0);

    // Full FIFO with a pop on the same edge as winner 0xB4.
    result_ready_i = 1'b0;
    step(0, 0, 0, 0, 1);
    check("s3_overflow_cleared", {31'b0, overflow_o}, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hB0 + i);
    for (int i = 0; i < 9; i++) begin
      result_ready_i = (i == 8);
      step(i < 5, 32'hB0 + i, i == 4, i >= 4, 0);
    end
    result_ready_i = 1'b0;
    check("s3_overflow", {31'b0, overflow_o}, 0);
    check("s3_wins", {24'b0, win_count_o}, 5);
    check("s3_head", result_nonce_o, 32'hB1);
    result_ready_i = 1'b1;
    idle(6);
    check("s3_sb_empty", exp_q.size(), 0);

    // Bubbles: success only in empty slots.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      step(i == 0, 32'hC0, i == 0, i == 2 || i == 3 || i == 5 || i == 6, 0);
    check("s4_wins", {24'b0, win_count_o}, 0);
    check("s4_valid", {31'b0, result_valid_o}, 0);
    check("s4_done", {31'b0, done_o}, 1);

    // Restart with two nonces in flight and one in the FIFO.
    result_ready_i = 1'b0;
    step(0, 0, 0, 0, 1);
    step(1, 32'hD0, 0, 0, 0);
    step(1, 32'hD1, 0, 0, 0);
    step(1, 32'hD2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    exp_q.push_back(32'hD0);
    step(0, 0, 0, 1, 0);
    check("s5_pre_valid", {31'b0, result_valid_o}, 1);
    check("s5_pre_wins", {24'b0, win_count_o}, 1);
    step(1, 32'hE0, 0, 1, 1);
    check("s5_valid", {31'b0, result_valid_o}, 0);
    check("s5_wins", {24'b0, win_count_o}, 0);
    check("s5_busy", {31'b0, busy_o}, 1);
    step(0, 0, 0, 1, 0);
    check("s5_inflight_ignored", {24'b0, win_count_o}, 0);
    idle(2);
    step(0, 0, 0, 1, 0);
    check("s5_coincident_ignored", {24'b0, win_count_o}, 0);

    // Asynchronous reset between edges mid-job.
    step(1, 32'hF0, 0, 0, 0);
    idle(3);
    exp_q.push_back(32'hF0);
    step(0, 0, 0, 1, 0);
    check("s6_pre_valid", {31'b0, result_valid_o}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("s6_valid", {31'b0, result_valid_o}, 0);
    check("s6_busy", {31'b0, busy_o}, 0);
    check("s6_done", {31'b0, done_o}, 0);
    check("s6_overflow", {31'b0, overflow_o}, 0);
    check("s6_wins", {24'b0, win_count_o}, 0);
    check("s6_nonce", result_nonce_o, 0);
    #3;
    rst_n = 1'b1;
    idle(2);
    check("s6_idle_busy", {31'b0, busy_o}, 0);
    check("s6_idle_done", {31'b0, done_o}, 0);

    // First start after reset is honoured.
    result_ready_i = 1'b1;
    step(0, 0, 0, 0, 1);
    exp_q.push_back(32'h6A);
    step(1, 32'h6A, 1, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0);
    check("s7_done", {31'b0, done_o}, 1);
    idle(3);
    check("s7_wins", {24'b0, win_count_o}, 1);
    check("s7_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
